// File: rtl/tt_um_serial_addsub.sv
// Bit-serial adder/subtractor with result parity. Operands arrive LSB-first; each
// sum bit is returned one cycle later, and flags plus the parallel result follow completion.
module tt_um_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: a bit is accepted on a rising edge where bit_valid=1 and clear=0;
  // sum_valid is high for exactly the cycle after each accepted bit, with no back-pressure.
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, pacc, sub_r, podd_r;
  logic [WIDTH-1:0] acc, acc_nxt, result;
  logic             sum_bit_r, sum_valid_r, done_r;
  logic             carry_out_r, overflow_r, parity_r;

  logic a_bit, b_bit, bit_valid, sub, clear, par_odd;
  logic accept, idle, last;
  logic sub_eff, podd_eff, cin, pacc_in, bx, s, cout, par_x;

  wire unused_inputs = &{ena, uio_in, ui_in[7:6], 1'b0};

  always_comb begin
    a_bit     = ui_in[0];
    b_bit     = ui_in[1];
    bit_valid = ui_in[2];
    sub       = ui_in[3];
    clear     = ui_in[4];
    par_odd   = ui_in[5];
    accept    = bit_valid & ~clear;
    idle      = (state == IDLE);
    last      = (cnt == CW'(WIDTH - 1));
    // Bit 0 is taken from IDLE, so it uses the live mode inputs and a fresh carry/parity.
    sub_eff   = idle ? sub : sub_r;
    podd_eff  = idle ? par_odd : podd_r;
    cin       = idle ? sub : carry;
    pacc_in   = idle ? 1'b0 : pacc;
    bx        = b_bit ^ sub_eff;
    s         = a_bit ^ bx ^ cin;
    cout      = (a_bit & bx) | (a_bit & cin) | (bx & cin);
    par_x     = pacc_in ^ s;
    acc_nxt      = acc;
    acc_nxt[cnt] = s;
  end

  always_comb begin
    state_nxt = state;
    if (clear)       state_nxt = IDLE;
    else if (accept) state_nxt = last ? IDLE : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      carry       <= 1'b0;
      pacc        <= 1'b0;
      sub_r       <= 1'b0;
      podd_r      <= 1'b0;
      acc         <= '0;
      result      <= '0;
      sum_bit_r   <= 1'b0;
      sum_valid_r <= 1'b0;
      done_r      <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      parity_r    <= 1'b0;
    end else begin
      sum_bit_r   <= 1'b0;
      sum_valid_r <= 1'b0;
      done_r      <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        carry <= 1'b0;
        pacc  <= 1'b0;
      end else if (accept) begin
        carry       <= cout;
        pacc        <= par_x;
        acc         <= acc_nxt;
        sum_bit_r   <= s;
        sum_valid_r <= 1'b1;
        if (idle) begin
          sub_r       <= sub;
          podd_r      <= par_odd;
          carry_out_r <= 1'b0;
          overflow_r  <= 1'b0;
          parity_r    <= 1'b0;
        end
        if (last) begin
          // Overflow compares the carry into the MSB with the carry out of it.
          cnt         <= '0;
          done_r      <= 1'b1;
          carry_out_r <= cout;
          overflow_r  <= cin ^ cout;
          parity_r    <= podd_eff ? par_x : ~par_x;
          result      <= acc_nxt;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign uo_out = {1'b0, (state == RUN), parity_r, overflow_r, done_r,
                   carry_out_r, sum_valid_r, sum_bit_r};
  assign uio_oe = 8'hFF;

  generate
    if (WIDTH >= 8) begin : g_wide
      assign uio_out = result[7:0];
    end else begin : g_narrow
      assign uio_out = {{(8 - WIDTH){1'b0}}, result};
    end
  endgenerate

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// Directed bench for tt_um_serial_addsub: an 8-bit and a 4-bit instance share clock and reset.
module tb_tt_um_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui8, uo8, uio8, oe8;
  logic [7:0] ui4, uo4, uio4, oe4;
  int         checks = 0;
  int         errors = 0;

  tt_um_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui8), .uo_out(uo8),
    .uio_in(8'h00), .uio_out(uio8), .uio_oe(oe8)
  );

  tt_um_serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui4), .uo_out(uo4),
    .uio_in(8'h00), .uio_out(uio4), .uio_oe(oe4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] uo_of(input int w);
    return (w == 8) ? uo8 : uo4;
  endfunction

  function automatic logic [7:0] uio_of(input int w);
    return (w == 8) ? uio8 : uio4;
  endfunction

  task automatic set_ui(input int w, input logic [7:0] v);
    if (w == 8) ui8 = v;
    else        ui4 = v;
  endtask

  task automatic gap(input int w);
    set_ui(w, 8'h00);
    tick();
    chk("gap_sum_valid", 32'(uo_of(w)[1]), 0);
    chk("gap_sum_bit", 32'(uo_of(w)[0]), 0);
  endtask

  task automatic drive_bit(input int w, input logic a, input logic b, input logic sub,
                           input logic podd, input logic exp_s, input bit first, input bit last);
    set_ui(w, {2'b00, podd, 1'b0, sub, 1'b1, b, a});
    tick();
    chk("sum_valid", 32'(uo_of(w)[1]), 1);
    chk("sum_bit", 32'(uo_of(w)[0]), 32'(exp_s));
    chk("busy", 32'(uo_of(w)[6]), last ? 0 : 1);
    if (!last) chk("done_early", 32'(uo_of(w)[3]), 0);
    if (first) chk("flags_cleared", 32'(uo_of(w)[5:4]) + 32'(uo_of(w)[2]), 0);
  endtask

  // sub/par_odd are inverted on bits after bit 0 to show they are only sampled once.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic podd, input logic [7:0] exp_r, input logic exp_c,
                        input logic exp_v, input logic exp_p, input int maxgap);
    for (int i = 0; i < w; i++) begin
      if (i > 0 && maxgap > 0) begin
        int n;
        n = $urandom_range(1, maxgap);
        for (int g = 0; g < n; g++) gap(w);
      end
      drive_bit(w, a[i], b[i], (i == 0) ? sub : ~sub, (i == 0) ? podd : ~podd,
                exp_r[i], i == 0, i == w - 1);
    end
    set_ui(w, 8'h00);
    chk("done", 32'(uo_of(w)[3]), 1);
    chk("carry_out", 32'(uo_of(w)[2]), 32'(exp_c));
    chk("overflow", 32'(uo_of(w)[4]), 32'(exp_v));
    chk("parity", 32'(uo_of(w)[5]), 32'(exp_p));
    chk("result", 32'(uio_of(w)), 32'(exp_r));
    chk("uo7", 32'(uo_of(w)[7]), 0);
  endtask

  task automatic after_done(input int w, input logic [7:0] exp_r, input logic exp_c,
                            input logic exp_v, input logic exp_p);
    tick();
    chk("done_pulse", 32'(uo_of(w)[3]), 0);
    chk("hold_flags", 32'({uo_of(w)[5], uo_of(w)[4], uo_of(w)[2]}), 32'({exp_p, exp_v, exp_c}));
    chk("hold_result", 32'(uio_of(w)), 32'(exp_r));
  endtask

  initial begin
    ui8 = 8'h00;
    ui4 = 8'h00;
    rst_n = 1'b0;
    #3;
    chk("rst_uo8", 32'(uo8), 0);
    chk("rst_uio8", 32'(uio8), 0);
    chk("rst_oe8", 32'(oe8), 32'hFF);
    chk("rst_uo4", 32'(uo4), 0);
    chk("rst_oe4", 32'(oe4), 32'hFF);
    #20;
    rst_n = 1'b1;
    tick();

    // 0x5A + 0x3C = 0x96, signed overflow, even-parity flag set
    run_op(8, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 0);
    after_done(8, 8'h96, 1'b0, 1'b1, 1'b1);

    // 0x10 - 0x20 = 0xF0 with borrow, odd parity flag
    run_op(8, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
    after_done(8, 8'hF0, 1'b0, 1'b0, 1'b0);

    // 0xFF + 0x01 then back-to-back 0x12 + 0x34 = 0x46
    run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    run_op(8, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 0);
    after_done(8, 8'h46, 1'b0, 1'b0, 1'b0);

    // First case again with 1-3 cycle gaps
    run_op(8, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 3);
    after_done(8, 8'h96, 1'b0, 1'b1, 1'b1);

    // Abort after 4 bits; clear together with bit_valid
    for (int i = 0; i < 4; i++) drive_bit(8, 1'b1, 1'b1, 1'b0, 1'b0, (i == 0) ? 1'b0 : 1'b1, i == 0, 1'b0);
    ui8 = 8'b0001_0111;
    tick();
    ui8 = 8'h00;
    chk("abort_done", 32'(uo8[3]), 0);
    chk("abort_busy", 32'(uo8[6]), 0);
    chk("abort_sum_valid", 32'(uo8[1]), 0);
    chk("abort_result", 32'(uio8), 32'h96);
    tick();
    chk("abort_no_done", 32'(uo8[3]), 0);
    run_op(8, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 0);
    after_done(8, 8'h03, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges after 3 bits
    for (int i = 0; i < 3; i++) drive_bit(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, i == 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_uo8", 32'(uo8), 0);
    chk("async_uio8", 32'(uio8), 0);
    chk("async_oe8", 32'(oe8), 32'hFF);
    ui8 = 8'h00;
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(uo8[3]), 0);
    run_op(8, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    after_done(8, 8'h80, 1'b0, 1'b1, 1'b0);

    // WIDTH=4: 0xA + 0x3 = 0xD, then 0xF + 0x1 back-to-back with 0xA + 0x3
    run_op(4, 8'h0A, 8'h03, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 0);
    after_done(4, 8'h0D, 1'b0, 1'b0, 1'b0);
    run_op(4, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    run_op(4, 8'h0A, 8'h03, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 0);
    after_done(4, 8'h0D, 1'b0, 1'b0, 1'b0);
    run_op(4, 8'h0A, 8'h03, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 2);
    after_done(4, 8'h0D, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_addsub.md
# tt_um_serial_addsub

Parametrised bit-serial adder/subtractor with result parity, packaged as a Tiny Tapeout user project. Operands arrive LSB-first, one bit pair per strobed cycle. Each sum bit is returned serially one cycle later. On completion the block reports carry/borrow, signed overflow and even/odd parity, and holds the parallel result low byte on the bidirectional pins. It generalises the team's combinational three-input parity cell to a WIDTH-bit sequential datapath.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits. Legal range 2..32.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  [0] a_bit, [1] b_bit, [2] bit_valid, [3] sub (0=add, 1=subtract), [4] clear (synchronous abort), [5] par_odd (0=even-parity flag, 1=odd), [7:6] unused.
- uo_out  output  8  [0] sum_bit, [1] sum_valid, [2] carry_out, [3] done, [4] overflow, [5] parity, [6] busy, [7] constant 0.
- uio_in  input  8  unused.
- uio_out  output  8  result[7:0] of the last completed operation; zero-extended when WIDTH<8.
- uio_oe  output  8  constant 8'hFF, including during reset.

## Operation
- FSM states are IDLE and RUN. A bit counter cnt spans 0..WIDTH-1. Registers: carry, result[WIDTH-1:0], and parity accumulator pacc.
- IDLE with bit_valid=1 accepts bit 0:
  - latch sub_r=sub and podd_r=par_odd;
  - carry_in for this bit = sub;
  - enter RUN; busy=1 from the next cycle.
- Every accepted bit i computes:
  - b' = b_bit ^ sub_r;
  - s = a_bit ^ b' ^ carry_in;
  - carry <= majority(a_bit, b', carry_in);
  - result[i] <= s; pacc <= pacc ^ s;
  - cnt <= cnt+1.
- Cycles with bit_valid=0 are gaps. A gap changes no state and sum_valid=0 in the following cycle.
- Bit WIDTH-1 accepted:
  - FSM returns to IDLE and cnt returns to 0;
  - next cycle: done=1 for exactly one cycle, busy=0;
  - carry_out = final carry. For subtract, 1 means no borrow (a>=b unsigned);
  - overflow = carry into MSB XOR carry out of MSB (two's-complement);
  - parity = ~(XOR of all sum bits) when podd_r=0; XOR of all sum bits when podd_r=1;
  - uio_out updates to the new result.
- carry_out, overflow, parity and uio_out hold until the next completion. carry_out, overflow and parity also clear to 0 when the next operation accepts bit 0.
- clear=1, in any state:
  - next state is IDLE; cnt, carry and pacc reset to 0;
  - no done and no sum_valid are generated;
  - result and uio_out keep their previous completed value.
- clear and bit_valid in the same cycle: clear wins and the bit is dropped.
- Back-to-back operations are allowed: a bit_valid during the done cycle is accepted as bit 0 of a new operation.

## Timing
- Reset (rst_n=0): immediately, without waiting for clk, uo_out=0, uio_out=0, FSM=IDLE, all registers 0. uio_oe stays 8'hFF.
- Reset asserted mid-operation discards the operation; there is no done.
- Serial latency: sum_bit/sum_valid appear in the cycle after the edge that samples the bit. sum_bit is meaningful only while sum_valid=1 and otherwise reads 0.
- Completion latency: done is asserted in the cycle after the edge sampling bit WIDTH-1. Minimum operation is WIDTH cycles, with done on cycle WIDTH+1.
- Throughput: one operation per WIDTH cycles with no idle cycle between operations.
- sub and par_odd are sampled only with bit 0. Changing them mid-operation has no effect.

## Test plan
Benches use WIDTH=8 unless noted.
- Add 0x5A+0x3C, sub=0, par_odd=0, valid for 8 consecutive cycles:
  - eight sum_valid pulses with serial bits 0,1,1,0,1,0,0,1 (0x96 LSB-first);
  - then done=1, carry_out=0, overflow=1, parity=1, uio_out=0x96.
- Subtract 0x10-0x20, sub=1, par_odd=1 -> uio_out=0xF0, carry_out=0 (borrow), overflow=0, parity=0.
- Add 0xFF+0x01, par_odd=0 -> uio_out=0x00, carry_out=1, overflow=0, parity=1. Then immediately start the next operation in the done cycle and check it completes correctly 8 cycles later.
- Repeat the first case with random 1-3 cycle gaps between bits:
  - identical result and flags;
  - exactly 8 sum_valid pulses;
  - no sum_valid during gaps.
- Abort: 4 bits, then clear=1 together with bit_valid=1:
  - no done; busy=0 the next cycle; uio_out unchanged;
  - a following full 0x01+0x02 yields 0x03.
- Async reset mid-operation (after 3 bits, rst_n low between edges):
  - uo_out=0 and uio_out=0 before the next edge;
  - after release, 0x7F+0x01 gives 0x80, overflow=1.
- Repeat the first and third cases with WIDTH=4, using 0xA+0x3 -> 0xD, carry_out=0, overflow=0.
